// File: rtl/cpu_host_ctrl.sv
// rtl/cpu_host_ctrl.sv - host-side run controller: preload, core reset/launch, timed run, readback
module cpu_host_ctrl #(
    parameter int TIMEOUT = 4096,
    parameter int RST_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rd_base,
    input  logic [8:0]  rd_len,
    input  logic        ld_valid,
    input  logic [7:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_reset,
    output logic        cpu_req,
    input  logic        cpu_done,
    output logic        mem_own,
    output logic        mem_wr_en,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        res_valid,
    output logic [7:0]  res_addr,
    output logic [7:0]  res_data,
    input  logic        res_ready,
    output logic        busy,
    output logic        run_done,
    output logic        timed_out,
    output logic [15:0] run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CRST, S_RUN, S_RDBK, S_FIN
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(RST_CYC - 1);
    localparam logic [15:0] TIMEOUT_M1  = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [7:0]  base_q;
    logic [8:0]  len_q;
    logic        first_run;
    logic        run_exit_done;
    logic        run_exit_tmo;
    logic        res_acc;
    logic [7:0]  rd_addr;

    // run_cycles is cleared on start, so zero inside RUN marks the launch cycle
    assign first_run     = (run_cycles == 16'd0);
    assign run_exit_done = (state == S_RUN) && !first_run && cpu_done;
    assign run_exit_tmo  = (state == S_RUN) && !run_exit_done && (run_cycles == TIMEOUT_M1);
    assign rd_addr       = base_q + cnt[7:0];
    assign res_acc       = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 16'd0;
            base_q     <= 8'd0;
            len_q      <= 9'd0;
            run_cycles <= 16'd0;
            timed_out  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == S_IDLE && start) begin
                base_q     <= rd_base;
                len_q      <= rd_len;
                run_cycles <= 16'd0;
                timed_out  <= 1'b0;
            end
            if (state == S_RUN)
                run_cycles <= run_cycles + 16'd1;
            if (run_exit_tmo)
                timed_out <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                cnt_nx = 16'd0;
                if (start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (ld_valid && ld_last) begin
                    state_nx = S_CRST;
                    cnt_nx   = 16'd0;
                end
            end
            S_CRST: begin
                if (cnt == RST_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = 16'd0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            S_RUN: begin
                if (run_exit_done || run_exit_tmo) begin
                    state_nx = S_RDBK;
                    cnt_nx   = 16'd0;
                end
            end
            S_RDBK: begin
                if (len_q == 9'd0) begin
                    state_nx = S_FIN;
                end else if (res_acc) begin
                    if (cnt[8:0] == len_q - 9'd1) state_nx = S_FIN;
                    else                          cnt_nx   = cnt + 16'd1;
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs are squelched during reset so an abandoned run emits nothing
    always_comb begin
        ld_ready  = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        res_valid = 1'b0;
        res_addr  = 8'd0;
        res_data  = 8'd0;
        cpu_req   = 1'b0;
        cpu_reset = reset || (state != S_RUN);
        mem_own   = reset || (state != S_RUN);
        busy      = (state != S_IDLE);
        run_done  = (state == S_FIN);
        case (state)
            S_LOAD: begin
                ld_ready  = !reset;
                mem_wr_en = !reset && ld_valid;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
            end
            S_RUN: begin
                cpu_req = !reset && first_run;
            end
            S_RDBK: begin
                mem_addr  = rd_addr;
                res_addr  = rd_addr;
                res_valid = !reset && (len_q != 9'd0);
                res_data  = res_valid ? mem_rdata : 8'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// tb/tb_cpu_host_ctrl.sv - directed self-checking bench for cpu_host_ctrl
module tb_cpu_host_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rd_base;
    logic [8:0]  rd_len;
    logic        ld_valid;
    logic [7:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_reset;
    logic        cpu_req;
    logic        cpu_done;
    logic        mem_own;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        res_valid;
    logic [7:0]  res_addr;
    logic [7:0]  res_data;
    logic        res_ready;
    logic        busy;
    logic        run_done;
    logic        timed_out;
    logic [15:0] run_cycles;

    int checks = 0;
    int errors = 0;

    cpu_host_ctrl #(.TIMEOUT(50), .RST_CYC(2)) dut (
        .clk(clk), .reset(reset), .start(start), .rd_base(rd_base), .rd_len(rd_len),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .cpu_reset(cpu_reset), .cpu_req(cpu_req), .cpu_done(cpu_done),
        .mem_own(mem_own), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
        .res_ready(res_ready), .busy(busy), .run_done(run_done), .timed_out(timed_out),
        .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // Data memory and core model: done rises done_after cycles after req (never if negative)
    logic [7:0] mem [256];
    int since_req = 0;
    int done_after;
    always @(posedge clk) begin
        if (mem_wr_en && mem_own) mem[mem_addr] <= mem_wdata;
        since_req <= cpu_reset ? 0 : since_req + 1;
    end
    assign mem_rdata = mem[mem_addr];
    assign cpu_done  = !cpu_reset && (done_after >= 0) && (since_req >= done_after);

    int cyc = 0;
    int n_wr = 0, n_req = 0, n_done = 0, n_rv = 0, n_bad = 0;
    int last_acc = 0, req_cyc = 0, run_end = 0, fin_cyc = 0;
    logic [15:0] res_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_addr = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ld_valid && ld_ready) last_acc = cyc;
        if (mem_wr_en) n_wr++;
        if (cpu_req) begin n_req++; req_cyc = cyc; end
        if (!cpu_reset) run_end = cyc;
        if (run_done) begin n_done++; fin_cyc = cyc; end
        if (res_valid) n_rv++;
        if (res_valid && res_ready) res_q.push_back({res_addr, res_data});
        if (prev_stall && !(res_valid && res_addr == prev_addr)) n_bad++;
        prev_stall = res_valid && !res_ready && !reset;
        prev_addr  = res_addr;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] base, input logic [8:0] len);
        start = 1'b1; rd_base = base; rd_len = len;
        tick;
        start = 1'b0;
    endtask

    task automatic load_beat(input logic [7:0] a, input logic [7:0] d, input logic last);
        ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
        tick;
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // Steps until run_done (bounded), driving res_ready from a per-valid-cycle pattern
    task automatic wait_fin(input bit bp, output bit ok);
        logic [5:0] pat;
        int k;
        pat = 6'b101101;
        k = 0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (res_valid) begin
                res_ready = (bp && k < 6) ? pat[k] : 1'b1;
                k++;
            end else begin
                res_ready = 1'b0;
            end
            tick;
            if (run_done) ok = 1'b1;
        end
        res_ready = 1'b0;
        tick;
    endtask

    initial begin
        int w0, r0, d0, q0, v0;
        bit ok;
        reset = 1'b1; start = 1'b0; rd_base = 8'd0; rd_len = 9'd0;
        ld_valid = 1'b0; ld_addr = 8'd0; ld_data = 8'd0; ld_last = 1'b0;
        res_ready = 1'b0; done_after = -1;
        repeat (3) tick;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_mem_own", mem_own, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_run_cycles", run_cycles, 0);
        chk("rst_timed_out", timed_out, 0);
        chk("rst_cpu_req", cpu_req, 0);
        reset = 1'b0;
        tick;

        // Basic run
        w0 = n_wr; r0 = n_req; d0 = n_done; q0 = res_q.size();
        done_after = 20;
        do_start(8'h10, 9'd3);
        chk("ld_ready_lat", ld_ready, 1);
        load_beat(8'h10, 8'hAA, 0);
        load_beat(8'h11, 8'hBB, 0);
        load_beat(8'h12, 8'hCC, 1);
        wait_fin(0, ok);
        chk("basic_fin", ok, 1);
        chk("basic_writes", n_wr - w0, 3);
        chk("basic_req_cnt", n_req - r0, 1);
        chk("basic_req_lat", req_cyc - last_acc, 3);
        chk("basic_run_cycles", run_cycles, 21);
        chk("basic_timed_out", timed_out, 0);
        chk("basic_beats", res_q.size() - q0, 3);
        chk("basic_d0", res_q[q0], 16'h10AA);
        chk("basic_d1", res_q[q0+1], 16'h11BB);
        chk("basic_d2", res_q[q0+2], 16'h12CC);
        chk("basic_run_done", n_done - d0, 1);
        chk("basic_idle", busy, 0);

        // Timeout, with a stray start outside IDLE that must be ignored
        q0 = res_q.size();
        done_after = -1;
        do_start(8'h10, 9'd2);
        load_beat(8'h40, 8'h01, 1);
        start = 1'b1; rd_base = 8'h80; rd_len = 9'd1;
        tick;
        start = 1'b0;
        wait_fin(0, ok);
        chk("tmo_fin", ok, 1);
        chk("tmo_flag", timed_out, 1);
        chk("tmo_run_cycles", run_cycles, 50);
        chk("tmo_beats", res_q.size() - q0, 2);
        chk("tmo_d0", res_q[q0], 16'h10AA);
        chk("tmo_d1", res_q[q0+1], 16'h11BB);

        // Wrap and backpressure
        q0 = res_q.size(); v0 = n_bad;
        done_after = 5;
        do_start(8'hFE, 9'd4);
        chk("wrap_timed_out_clr", timed_out, 0);
        load_beat(8'hFE, 8'h11, 0);
        load_beat(8'hFF, 8'h22, 0);
        load_beat(8'h00, 8'h33, 0);
        load_beat(8'h01, 8'h44, 1);
        wait_fin(1, ok);
        chk("wrap_fin", ok, 1);
        chk("wrap_run_cycles", run_cycles, 6);
        chk("wrap_beats", res_q.size() - q0, 4);
        chk("wrap_b0", res_q[q0], 16'hFE11);
        chk("wrap_b1", res_q[q0+1], 16'hFF22);
        chk("wrap_b2", res_q[q0+2], 16'h0033);
        chk("wrap_b3", res_q[q0+3], 16'h0144);
        chk("wrap_stall_stable", n_bad - v0, 0);

        // rd_len=0 and done already high on the first RUN cycle
        v0 = n_rv; d0 = n_done;
        done_after = 0;
        do_start(8'h10, 9'd0);
        load_beat(8'h30, 8'h99, 1);
        wait_fin(0, ok);
        chk("zero_fin", ok, 1);
        chk("zero_run_cycles", run_cycles, 2);
        chk("zero_no_valid", n_rv - v0, 0);
        chk("zero_fin_lat", fin_cyc - run_end, 2);
        chk("zero_run_done", n_done - d0, 1);

        // Reset in the middle of readback after two beats
        q0 = res_q.size();
        done_after = 20;
        do_start(8'h10, 9'd4);
        load_beat(8'h20, 8'h55, 1);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            res_ready = res_valid;
            tick;
            if (res_q.size() - q0 >= 2) ok = 1'b1;
        end
        chk("mid_reached", ok, 1);
        reset = 1'b1; res_ready = 1'b0;
        tick;
        chk("mid_idle", busy, 0);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_cpu_reset", cpu_reset, 1);
        chk("mid_timed_out", timed_out, 0);
        chk("mid_run_cycles", run_cycles, 0);
        reset = 1'b0;
        tick;
        chk("mid_beats", res_q.size() - q0, 2);

        q0 = res_q.size();
        do_start(8'h11, 9'd2);
        load_beat(8'h21, 8'h66, 1);
        wait_fin(0, ok);
        chk("post_fin", ok, 1);
        chk("post_run_cycles", run_cycles, 21);
        chk("post_beats", res_q.size() - q0, 2);
        chk("post_d0", res_q[q0], 16'h11BB);
        chk("post_d1", res_q[q0+1], 16'h12CC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_host_ctrl.md
# cpu_host_ctrl

Host-side run controller for the 9-bit-ISA core: the initiator end of the core's reset/req/done handshake. It preloads data memory through a backdoor write stream, holds the core in reset, launches a run with a one-cycle `req`, times the run until `done` or timeout, then streams a programmable window of data memory back out. It sits between the bench or host interface and the core top level, muxing ownership of the data-memory port.

## Interface
Parameters:
- `TIMEOUT`, default 4096: maximum RUN cycles before abort; legal range 2..65535.
- `RST_CYC`, default 2: core reset cycles between the end of preload and launch; minimum 1.

Ports (reset: `reset`, synchronous, active-high; clock: `clk`):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a run; sampled only in IDLE.
- `rd_base` in 8: readback start address; latched on accepted `start`.
- `rd_len` in 9: readback word count, 0..256; latched on accepted `start`.
- `ld_valid` in 1: preload beat valid.
- `ld_addr` in 8: preload address.
- `ld_data` in 8: preload data.
- `ld_last` in 1: final preload beat.
- `ld_ready` out 1: preload beat accept.
- `cpu_reset` out 1: reset to the core.
- `cpu_req` out 1: launch pulse to the core.
- `cpu_done` in 1: completion flag from the core.
- `mem_own` out 1: host owns the data-memory port; when 0, the core drives it.
- `mem_wr_en` out 1: data-memory write enable.
- `mem_addr` out 8: data-memory address.
- `mem_wdata` out 8: data-memory write data.
- `mem_rdata` in 8: data-memory read data; combinational read.
- `res_valid` out 1: readback beat valid.
- `res_addr` out 8: readback address.
- `res_data` out 8: readback data.
- `res_ready` in 1: readback beat accept.
- `busy` out 1: not IDLE.
- `run_done` out 1: one-cycle end-of-sequence pulse.
- `timed_out` out 1: last run hit `TIMEOUT`; sticky until the next accepted `start`.
- `run_cycles` out 16: RUN-state cycle count of the last run.

## Operation
- States: IDLE, LOAD, CRST, RUN, RDBK, FIN.
- IDLE:
  - `start` → LOAD; latch `rd_base` and `rd_len`; clear `run_cycles` and `timed_out`.
- LOAD:
  - `ld_ready`=1.
  - Beat accepted when `ld_valid`&`ld_ready`: `mem_wr_en`=1, `mem_addr`=`ld_addr`, `mem_wdata`=`ld_data` in the same cycle.
  - Accepted beat with `ld_last` → CRST, with cycle counter = 0. Zero-beat preload is not supported; send one dummy beat with `ld_last`.
- CRST:
  - Counts `RST_CYC` cycles, then → RUN.
- RUN:
  - `cpu_reset`=0, `mem_own`=0; all host memory outputs 0.
  - `cpu_req`=1 on the first RUN cycle only.
  - `run_cycles` increments every RUN cycle, including the first.
  - `cpu_done` is ignored on the first RUN cycle.
  - From the second cycle on, `cpu_done`=1 → RDBK.
  - If `run_cycles` reaches `TIMEOUT` without `cpu_done`: set `timed_out`, → RDBK. Readback still occurs for debug.
  - Done and timeout in the same cycle: done wins; `timed_out` stays 0.
- RDBK:
  - Index i runs from 0.
  - `mem_addr` = `res_addr` = (`rd_base`+i) mod 256; wraps from 255 to 0.
  - `res_data`=`mem_rdata`; `res_valid`=1.
  - Advance on `res_valid`&`res_ready`.
  - After accepting beat `rd_len`-1 → FIN.
  - `rd_len`=0: RDBK lasts one cycle with `res_valid`=0, then → FIN.
- FIN:
  - `run_done`=1 for one cycle, then → IDLE.
- `cpu_reset`=1 in every state except RUN, which freezes the core after completion.
- `mem_own`=1 in every state except RUN.
- `busy`=1 in every state except IDLE.
- `reset` mid-operation: return to IDLE next edge, abandoning any run or readback; no further `res_valid` or memory writes.
  - Reset clears `timed_out` and `run_cycles`.
  - Reset holds `cpu_reset`=1.

## Timing
- All state registers update on the `clk` rising edge.
- `ld_ready`, `mem_*`, `res_*`, `cpu_req` and `cpu_reset` decode combinationally from state and inputs.
- Reset values:
  - state=IDLE.
  - `cpu_reset`=1, `mem_own`=1.
  - All other outputs 0, including `run_cycles`=0 and `timed_out`=0.
- Latency, accepted `start` to first `ld_ready`: 1 cycle.
- Latency, `ld_last` accept to `cpu_req`: `RST_CYC`+1 cycles.
- Latency, `cpu_done` to first `res_valid`: 1 cycle.
- Latency, last readback accept to `run_done`: 1 cycle.
- `run_done` to earliest next LOAD: 2 cycles (FIN→IDLE, then `start`).
- Readback is 1 beat/cycle when `res_ready` is held high.
- `res_valid` and `res_addr` hold stable while stalled.
- `start` asserted outside IDLE: ignored, with no latching.

## Test plan
- Basic run:
  - Stimulus: preload 3 beats, (0x10,0xAA), (0x11,0xBB), (0x12,0xCC last); `rd_base`=0x10, `rd_len`=3; core model asserts done 20 cycles after `req`.
  - Required: 3 memory writes in LOAD; `cpu_req` pulses exactly once, 3 cycles after the last accept; `run_cycles`=21; `res_data` sequence 0xAA, 0xBB, 0xCC; `run_done` pulses once.
- Timeout:
  - Stimulus: `TIMEOUT`=50; `cpu_done` never asserted.
  - Required: `timed_out`=1, `run_cycles`=50, RDBK still completes.
- Wrap and backpressure:
  - Stimulus: `rd_base`=0xFE, `rd_len`=4; `res_ready` toggles 1,0,1,1,0,1.
  - Required: addresses 0xFE, 0xFF, 0x00, 0x01 each delivered once, held stable while stalled.
- Edge cases:
  - `rd_len`=0 → no `res_valid`, `run_done` one cycle after RDBK entry.
  - `cpu_done` already high on the first RUN cycle → ignored; exit on the second cycle with `run_cycles`=2.
- Reset mid-RDBK after 2 beats:
  - Required: IDLE next cycle; `res_valid`=0, `cpu_reset`=1, `timed_out`=0, `run_cycles`=0.
  - A subsequent `start` runs normally.
